// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction ROM port, decoder feedback, label-table write port and status.
// master = fetch unit side, slave = ROM/decoder/controller side.
// Optional cycle_count_o exists only when FETCH_CYCLE_COUNT_EN is defined.
interface fetch_unit_if;
    logic       start;
    logic [9:0] start_addr;
    logic [9:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] instr_o;
    logic       instr_valid_o;
    logic       halt_i;
    logic       branch_i;
    logic       label_read_i;
    logic [3:0] branch_addr_i;
    logic       zero_i;
    logic       stall_i;
    logic       lut_we;
    logic [3:0] lut_idx;
    logic [9:0] lut_data;
    logic [9:0] pc_o;
    logic       done_o;
`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cycle_count_o;
`endif

    modport master (
        input  start, start_addr, imem_data, halt_i, branch_i, label_read_i,
               branch_addr_i, zero_i, stall_i, lut_we, lut_idx, lut_data,
`ifdef FETCH_CYCLE_COUNT_EN
        output cycle_count_o,
`endif
        output imem_addr, instr_o, instr_valid_o, pc_o, done_o
    );

    modport slave (
        output start, start_addr, imem_data, halt_i, branch_i, label_read_i,
               branch_addr_i, zero_i, stall_i, lut_we, lut_idx, lut_data,
`ifdef FETCH_CYCLE_COUNT_EN
        input  cycle_count_o,
`endif
        input  imem_addr, instr_o, instr_valid_o, pc_o, done_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: pc + label-table redirect over a combinational ROM; optional FETCH_CYCLE_COUNT_EN cycle counter.
// Latency: ROM word registered on instr_o one edge after pc presents it; taken redirect costs one bubble.
// Backpressure: stall_i freezes pc, instr_o, instr_valid_o and state; halt/redirect not evaluated while stalled.
module fetch_unit (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [9:0] pc;
    logic [7:0] instr;
    logic       instr_valid;
    logic [9:0] lut [16];
    logic       taken;
    logic       halting;
    logic       start_acc;
    logic       done;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode: start only counts outside RUN, halt only on a live unstalled instruction
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HALTED: if (bus.start) state_nxt = RUN;
            RUN:          if (!bus.stall_i && instr_valid && bus.halt_i) state_nxt = HALTED;
            default:      state_nxt = IDLE;
        endcase
    end

    // Output/control decode from the current state and the instruction in flight
    always_comb begin
        done      = (state == HALTED);
        start_acc = (state != RUN) && bus.start;
        halting   = instr_valid && bus.halt_i;
        taken     = instr_valid && bus.label_read_i && (!bus.branch_i || bus.zero_i);
    end

    // pc / instruction register / label table; the redirect reads lut before this edge's write lands
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            instr       <= 8'h00;
            instr_valid <= 1'b0;
            for (int i = 0; i < 16; i++) lut[i] <= '0;
        end else begin
            if (bus.lut_we) lut[bus.lut_idx] <= bus.lut_data;
            if (state == RUN) begin
                if (!bus.stall_i) begin
                    if (halting) begin
                        instr_valid <= 1'b0;
                    end else if (taken) begin
                        pc          <= lut[bus.branch_addr_i];
                        instr_valid <= 1'b0;
                    end else begin
                        instr       <= bus.imem_data;
                        instr_valid <= 1'b1;
                        pc          <= pc + 10'd1;
                    end
                end
            end else begin
                instr_valid <= 1'b0;
                if (start_acc) pc <= bus.start_addr;
            end
        end
    end

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cycle_cnt;

    // Saturating count of RUN cycles (stalls included), cleared by an accepted start
    always_ff @(posedge clk) begin
        if (reset)                                    cycle_cnt <= '0;
        else if (start_acc)                           cycle_cnt <= '0;
        else if (state == RUN && cycle_cnt != 16'hFFFF) cycle_cnt <= cycle_cnt + 16'd1;
    end

    assign bus.cycle_count_o = cycle_cnt;
`endif

    assign bus.imem_addr     = pc;
    assign bus.pc_o          = pc;
    assign bus.instr_o       = instr;
    assign bus.instr_valid_o = instr_valid;
    assign bus.done_o        = done;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, jump, beq0, lut write hazard, stall+halt, wrap, reset.
// The bench acts as ROM (rom[i] = i[7:0] with a few overrides) and as the decoder.
// Counter checks run only when FETCH_CYCLE_COUNT_EN is defined.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;
    logic [7:0] rom [1024];

    fetch_unit_if bus();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = rom[bus.imem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ctl_clear;
        bus.halt_i = 0; bus.branch_i = 0; bus.label_read_i = 0;
        bus.branch_addr_i = 0; bus.zero_i = 0; bus.stall_i = 0;
        bus.lut_we = 0; bus.start = 0;
    endtask

    task automatic lut_write(input logic [3:0] idx, input logic [9:0] data);
        bus.lut_we = 1; bus.lut_idx = idx; bus.lut_data = data;
        tick();
        bus.lut_we = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = i[7:0];
        rom[10] = 8'h00; rom[11] = 8'h10; rom[12] = 8'h20; rom[40] = 8'hA5;

        reset = 1;
        ctl_clear();
        bus.start_addr = 0; bus.lut_idx = 0; bus.lut_data = 0;
        tick(); tick();
        check("rst_pc", bus.pc_o, 0);
        check("rst_imem_addr", bus.imem_addr, 0);
        check("rst_valid", bus.instr_valid_o, 0);
        check("rst_instr", bus.instr_o, 8'h00);
        check("rst_done", bus.done_o, 0);
        reset = 0;

        lut_write(3, 40);
        lut_write(5, 200);
        lut_write(7, 300);
        check("idle_valid", bus.instr_valid_o, 0);

        // sequential fetch from 10
        bus.start = 1; bus.start_addr = 10;
        tick();
        bus.start = 0;
        check("start_pc", bus.pc_o, 10);
        check("start_valid", bus.instr_valid_o, 0);
        tick();
        check("seq0_instr", bus.instr_o, 8'h00); check("seq0_pc", bus.pc_o, 11);
        check("seq0_valid", bus.instr_valid_o, 1);
        tick();
        check("seq1_instr", bus.instr_o, 8'h10); check("seq1_pc", bus.pc_o, 12);
        tick();
        check("seq2_instr", bus.instr_o, 8'h20); check("seq2_pc", bus.pc_o, 13);

        // jump via lut[3]=40; controls left asserted through the bubble must be ignored
        bus.label_read_i = 1; bus.branch_i = 0; bus.branch_addr_i = 3;
        tick();
        check("jmp_valid", bus.instr_valid_o, 0); check("jmp_pc", bus.pc_o, 40);
        tick();
        check("jmp_instr", bus.instr_o, 8'hA5); check("jmp_pc2", bus.pc_o, 41);
        check("jmp_valid2", bus.instr_valid_o, 1);

        // beq0 not taken, then taken
        bus.branch_i = 1; bus.label_read_i = 1; bus.zero_i = 0; bus.branch_addr_i = 5;
        tick();
        check("beq_nt_pc", bus.pc_o, 42); check("beq_nt_instr", bus.instr_o, 8'h29);
        check("beq_nt_valid", bus.instr_valid_o, 1);
        bus.zero_i = 1;
        tick();
        check("beq_t_pc", bus.pc_o, 200); check("beq_t_valid", bus.instr_valid_o, 0);
        ctl_clear();
        tick();
        check("beq_t_instr", bus.instr_o, 8'hC8); check("beq_t_pc2", bus.pc_o, 201);

        // redirect coincident with a write to the same lut entry uses the old target
        bus.label_read_i = 1; bus.branch_addr_i = 7;
        bus.lut_we = 1; bus.lut_idx = 7; bus.lut_data = 500;
        tick();
        check("lut_old_pc", bus.pc_o, 300);
        ctl_clear();
        tick();
        check("lut_old_instr", bus.instr_o, 8'h2C);
        bus.label_read_i = 1; bus.branch_addr_i = 7;
        tick();
        check("lut_new_pc", bus.pc_o, 500);
        ctl_clear();
        tick();
        check("lut_new_instr", bus.instr_o, 8'hF4); check("lut_new_pc2", bus.pc_o, 501);

        // stall overrides halt for three cycles
        bus.halt_i = 1; bus.stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", bus.pc_o, 501); check("stall_instr", bus.instr_o, 8'hF4);
            check("stall_valid", bus.instr_valid_o, 1); check("stall_done", bus.done_o, 0);
        end
        bus.stall_i = 0;
        tick();
        check("halt_done", bus.done_o, 1); check("halt_valid", bus.instr_valid_o, 0);
        check("halt_pc", bus.pc_o, 501);
        bus.halt_i = 0;
        tick();
        check("halted_done", bus.done_o, 1); check("halted_pc", bus.pc_o, 501);

        // restart from HALTED near the top of the address space, wrap 1023->0
        bus.start = 1; bus.start_addr = 1022;
        tick();
        bus.start = 0;
        check("restart_done", bus.done_o, 0); check("restart_pc", bus.pc_o, 1022);
        tick();
        check("wrap_pc1023", bus.pc_o, 1023); check("wrap_instr", bus.instr_o, 8'hFE);
        tick();
        check("wrap_pc0", bus.pc_o, 0); check("wrap_instr2", bus.instr_o, 8'hFF);
        bus.start = 1; bus.start_addr = 10;
        tick();
        bus.start = 0;
        check("run_start_ignored", bus.pc_o, 1);

        // reset mid-RUN with a coincident lut write
        reset = 1; bus.lut_we = 1; bus.lut_idx = 3; bus.lut_data = 99;
        tick();
        check("mrst_pc", bus.pc_o, 0); check("mrst_valid", bus.instr_valid_o, 0);
        check("mrst_instr", bus.instr_o, 8'h00); check("mrst_done", bus.done_o, 0);
        reset = 0; bus.lut_we = 0;
        bus.start = 1; bus.start_addr = 50;
        tick();
        bus.start = 0;
        tick();
        check("mrst_run_instr", bus.instr_o, 8'h32);
        bus.label_read_i = 1; bus.branch_addr_i = 3;
        tick();
        check("mrst_lut_zero", bus.pc_o, 0);
        ctl_clear();
        tick();

`ifdef FETCH_CYCLE_COUNT_EN
        bus.halt_i = 1;
        tick();
        bus.halt_i = 0;
        check("cnt_halted", bus.done_o, 1);
        bus.start = 1; bus.start_addr = 100;
        tick();
        bus.start = 0;
        check("cnt_clear", bus.cycle_count_o, 0);
        tick();
        check("cnt_one", bus.cycle_count_o, 1);
        repeat (70000) tick();
        check("cnt_sat", bus.cycle_count_o, 16'hFFFF);
        bus.halt_i = 1;
        tick();
        bus.halt_i = 0;
        check("cnt_sat_halt", bus.cycle_count_o, 16'hFFFF);
        bus.start = 1;
        tick();
        bus.start = 0;
        check("cnt_restart_clear", bus.cycle_count_o, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  begin execution at start_addr; sampled in IDLE and HALTED only.
REQ-004 start_addr  in  10  first instruction address.
REQ-005 imem_addr  out  10  instruction ROM address; equals pc combinationally.
REQ-006 imem_data  in  8  ROM word at imem_addr, valid in the same cycle (combinational ROM).
REQ-007 instr_o  out  8  instruction register, feeds the decoder.
REQ-008 instr_valid_o  out  1  instr_o holds a live instruction.
REQ-009 halt_i, branch_i, label_read_i  in  1 each  decoder outputs for instr_o.
REQ-010 branch_addr_i  in  4  decoder label index.
REQ-011 zero_i  in  1  beq0 condition (v0 == 0) from the datapath.
REQ-012 stall_i  in  1  downstream not ready; freeze fetch.
REQ-013 lut_we  in  1, lut_idx  in  4, lut_data  in  10  label-table write port.
REQ-014 pc_o  out  10  current pc.
REQ-015 done_o  out  1  high while in HALTED.

Function
REQ-016 States IDLE, RUN, HALTED; 16x10 label table; 10-bit pc.
REQ-017 IDLE: instr_valid_o=0; on start, pc<=start_addr and go to RUN.
REQ-018 RUN priority per cycle: stall > halt > redirect > sequential.
REQ-019 Stall: stall_i=1 holds pc, instr_o, instr_valid_o and state; halt and redirect are not evaluated.
REQ-020 Halt: instr_valid_o=1 and halt_i=1 -> go to HALTED, instr_valid_o<=0, pc holds.
REQ-021 Taken = instr_valid_o & label_read_i & (~branch_i | zero_i); taken -> pc<=lut[branch_addr_i], instr_valid_o<=0 (one-cycle bubble; fetched word discarded).
REQ-022 Sequential: instr_o<=imem_data, instr_valid_o<=1, pc<=pc+1.
REQ-023 pc increment wraps 1023->0 without a flag.
REQ-024 Control inputs are ignored while instr_valid_o=0.
REQ-025 start in RUN is ignored; start in HALTED behaves as in IDLE (restart from start_addr, done_o falls the next cycle).
REQ-026 lut_we writes lut[lut_idx]<=lut_data at the edge in any state. A same-cycle redirect reading that index uses the old value.
REQ-027 Redirect latency: target word appears on instr_o two edges after the taken branch is presented on instr_o.

Reset
REQ-028 Reset forces state IDLE, pc=0, instr_o=8'h00, instr_valid_o=0, done_o=0, all label entries=0.
REQ-029 Reset overrides every input, including mid-RUN, mid-stall and a coincident lut_we.

Configuration
REQ-030 With FETCH_CYCLE_COUNT_EN defined, add output cycle_count_o[15:0]: it counts RUN cycles including stalls, saturates at 16'hFFFF, clears on reset and on an accepted start.
REQ-031 Without FETCH_CYCLE_COUNT_EN, the port and counter are absent and all other behaviour is identical.

Verification
REQ-032 Sequential: start_addr=10, ROM[10..12]=00,10,20, no stalls -> instr_o 00,10,20 on consecutive cycles, pc_o 11,12,13.
REQ-033 Jump: lut[3]=40, instr_o=j with label_read_i=1, branch_i=0, branch_addr_i=3 -> next cycle instr_valid_o=0 and pc_o=40; following cycle instr_o=ROM[40].
REQ-034 beq0: branch_i=1, label_read_i=1; zero_i=0 -> no redirect, pc+1. zero_i=1 -> pc<=lut index target.
REQ-035 Stall + halt: stall_i=1 for 3 cycles with halt_i=1 -> pc and instr_o frozen, done_o=0. stall_i drops -> HALTED next edge, done_o=1. start -> RUN at start_addr.
REQ-036 Wrap and reset: start_addr=1022 -> pc_o 1023, then 0. Reset asserted mid-RUN -> next edge pc_o=0, instr_valid_o=0, label table reads 0.
REQ-037 With the macro: 70000 RUN cycles -> cycle_count_o=16'hFFFF, and it clears on restart.
